// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - fetch/data request ports and shared SRAM-style bus of the arbiter
interface sram_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    // slave: the arbiter itself; master: requesters plus the bus bridge
    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata,
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output bus_req, bus_wr, bus_addr, bus_wdata, bus_wstrb,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata,
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  bus_req, bus_wr, bus_addr, bus_wdata, bus_wstrb,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - fetch/data arbiter for one SRAM-style port; ARB_RR_EN selects round-robin ties
module sram_bus_arbiter (
    input  logic                clk,
    input  logic                reset,
    sram_bus_arbiter_if.slave   arb_if
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        if_pend_q, if_pend_d;
    logic [31:0] if_paddr_q, if_paddr_d;
    logic        mem_pend_q, mem_pend_d;
    logic        mem_pwr_q, mem_pwr_d;
    logic [31:0] mem_paddr_q, mem_paddr_d;
    logic [31:0] mem_pwdata_q, mem_pwdata_d;
    logic [3:0]  mem_pwstrb_q, mem_pwstrb_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_wr_q, bus_wr_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        complete, can_grant, mem_first;
    logic        if_take, mem_take, if_avail, mem_avail;
    logic        grant_if, grant_mem;
    logic [31:0] if_addr_eff, mem_addr_eff, mem_wdata_eff;
    logic        mem_wr_eff;
    logic [3:0]  mem_wstrb_eff;

    always_comb begin
        complete = ((state_q == S_ADDR) && arb_if.bus_addr_ok && arb_if.bus_data_ok)
                || ((state_q == S_DATA) && arb_if.bus_data_ok);
        can_grant = (state_q == S_IDLE) || complete;

        // a source being served may re-request only on the edge its transaction completes
        if_take  = arb_if.if_req && !if_pend_q
                && !((state_q != S_IDLE) && (owner_q == OWN_IF) && !complete);
        mem_take = arb_if.mem_req && !mem_pend_q
                && !((state_q != S_IDLE) && (owner_q == OWN_MEM) && !complete);
        if_avail  = if_pend_q || if_take;
        mem_avail = mem_pend_q || mem_take;

        if_addr_eff   = if_pend_q  ? if_paddr_q   : arb_if.if_addr;
        mem_wr_eff    = mem_pend_q ? mem_pwr_q    : arb_if.mem_wr;
        mem_addr_eff  = mem_pend_q ? mem_paddr_q  : arb_if.mem_addr;
        mem_wdata_eff = mem_pend_q ? mem_pwdata_q : arb_if.mem_wdata;
        mem_wstrb_eff = mem_pend_q ? mem_pwstrb_q : arb_if.mem_wstrb;

`ifdef ARB_RR_EN
        mem_first = (owner_q == OWN_IF);
`else
        mem_first = 1'b1;
`endif
        grant_mem = can_grant && mem_avail && (!if_avail || mem_first);
        grant_if  = can_grant && if_avail && !grant_mem;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        if_pend_d    = if_pend_q;
        if_paddr_d   = if_paddr_q;
        mem_pend_d   = mem_pend_q;
        mem_pwr_d    = mem_pwr_q;
        mem_paddr_d  = mem_paddr_q;
        mem_pwdata_d = mem_pwdata_q;
        mem_pwstrb_d = mem_pwstrb_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        if_ready_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = mem_rdata_q;

        if (if_take) begin
            if_pend_d  = 1'b1;
            if_paddr_d = arb_if.if_addr;
        end
        if (mem_take) begin
            mem_pend_d   = 1'b1;
            mem_pwr_d    = arb_if.mem_wr;
            mem_paddr_d  = arb_if.mem_addr;
            mem_pwdata_d = arb_if.mem_wdata;
            mem_pwstrb_d = arb_if.mem_wstrb;
        end

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ADDR: begin
                if (arb_if.bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    state_d   = arb_if.bus_data_ok ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (arb_if.bus_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            if (owner_q == OWN_IF) begin
                if_ready_d = 1'b1;
                if_rdata_d = arb_if.bus_rdata;
            end else begin
                mem_ready_d = 1'b1;
                mem_rdata_d = bus_wr_q ? 32'h0 : arb_if.bus_rdata;
            end
        end

        // a grant overrides the fall to IDLE so back-to-back transfers have no bubble
        if (grant_mem) begin
            mem_pend_d  = 1'b0;
            owner_d     = OWN_MEM;
            state_d     = S_ADDR;
            bus_req_d   = 1'b1;
            bus_wr_d    = mem_wr_eff;
            bus_addr_d  = mem_addr_eff;
            bus_wdata_d = mem_wr_eff ? mem_wdata_eff : 32'h0;
            bus_wstrb_d = mem_wr_eff ? mem_wstrb_eff : 4'b0000;
        end else if (grant_if) begin
            if_pend_d   = 1'b0;
            owner_d     = OWN_IF;
            state_d     = S_ADDR;
            bus_req_d   = 1'b1;
            bus_wr_d    = 1'b0;
            bus_addr_d  = if_addr_eff;
            bus_wdata_d = 32'h0;
            bus_wstrb_d = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            if_pend_q    <= 1'b0;
            if_paddr_q   <= 32'h0;
            mem_pend_q   <= 1'b0;
            mem_pwr_q    <= 1'b0;
            mem_paddr_q  <= 32'h0;
            mem_pwdata_q <= 32'h0;
            mem_pwstrb_q <= 4'b0000;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_wstrb_q  <= 4'b0000;
            if_ready_q   <= 1'b0;
            if_rdata_q   <= 32'h0;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            if_pend_q    <= if_pend_d;
            if_paddr_q   <= if_paddr_d;
            mem_pend_q   <= mem_pend_d;
            mem_pwr_q    <= mem_pwr_d;
            mem_paddr_q  <= mem_paddr_d;
            mem_pwdata_q <= mem_pwdata_d;
            mem_pwstrb_q <= mem_pwstrb_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            if_ready_q   <= if_ready_d;
            if_rdata_q   <= if_rdata_d;
            mem_ready_q  <= mem_ready_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign arb_if.bus_req   = bus_req_q;
    assign arb_if.bus_wr    = bus_wr_q;
    assign arb_if.bus_addr  = bus_addr_q;
    assign arb_if.bus_wdata = bus_wdata_q;
    assign arb_if.bus_wstrb = bus_wstrb_q;
    assign arb_if.if_ready  = if_ready_q;
    assign arb_if.if_rdata  = if_rdata_q;
    assign arb_if.mem_ready = mem_ready_q;
    assign arb_if.mem_rdata = mem_rdata_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - vector table plus scoreboard bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
    logic clk;
    logic reset;
    sram_bus_arbiter_if bif();

    sram_bus_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .arb_if (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_if;
        logic [31:0] if_addr;
        logic [31:0] exp_if_rdata;
        logic        do_mem;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic [31:0] exp_mem_rdata;
        int          aw;
        int          dw;
        logic        same;
        int          exp_lat;
        int          exp_breq;
    } vec_t;

    typedef struct {
        logic        is_mem;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_ready_cyc = 0;
    int   ready_cnt = 0;
    int   breq_cnt = 0;
    int   aw_cfg = 0;
    int   dw_cfg = 0;
    logic same_cfg = 1'b0;
    logic dpend = 1'b0;
    int   acnt = 0;
    int   dcnt = 0;
    logic [31:0] daddr = 32'h0;
    logic rr_mode;
    logic model_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'hbfc0_0000) ? 32'h3c08_7fff : (a ^ 32'h1234_5678);
    endfunction

    // bus slave with programmable accept and response waits
    initial begin
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'b0;
        bif.bus_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            bif.bus_addr_ok = 1'b0;
            bif.bus_data_ok = 1'b0;
            if (dpend) begin
                if (dcnt == dw_cfg) begin
                    bif.bus_data_ok = 1'b1;
                    bif.bus_rdata   = slave_data(daddr);
                    dpend = 1'b0;
                end else begin
                    dcnt++;
                end
            end else if (bif.bus_req && !reset) begin
                if (acnt == aw_cfg) begin
                    bif.bus_addr_ok = 1'b1;
                    acnt  = 0;
                    daddr = bif.bus_addr;
                    if (same_cfg) begin
                        bif.bus_data_ok = 1'b1;
                        bif.bus_rdata   = slave_data(bif.bus_addr);
                    end else begin
                        dpend = 1'b1;
                        dcnt  = 0;
                    end
                end else begin
                    acnt++;
                end
            end
        end
    end

    // monitor: retire ready pulses first, then check the bus request against the head entry
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bif.if_ready || bif.mem_ready) begin
                    chk("ready_exclusive", {63'h0, bif.if_ready && bif.mem_ready}, 64'h0);
                    chk("ready_expected", {63'h0, q.size() != 0}, 64'h1);
                    if (q.size() != 0) begin
                        chk("ready_src", {63'h0, bif.mem_ready}, {63'h0, q[0].is_mem});
                        chk("rdata", {32'h0, bif.mem_ready ? bif.mem_rdata : bif.if_rdata},
                            {32'h0, q[0].rdata});
                        void'(q.pop_front());
                    end
                    last_ready_cyc = cyc;
                    ready_cnt++;
                end
                if (bif.bus_req) begin
                    breq_cnt++;
                    chk("bus_req_expected", {63'h0, q.size() != 0}, 64'h1);
                    if (q.size() != 0) begin
                        chk("bus_addr", {32'h0, bif.bus_addr}, {32'h0, q[0].addr});
                        chk("bus_wr", {63'h0, bif.bus_wr}, {63'h0, q[0].wr});
                        chk("bus_wstrb", {60'h0, bif.bus_wstrb}, {60'h0, q[0].wstrb});
                        if (q[0].wr) chk("bus_wdata", {32'h0, bif.bus_wdata}, {32'h0, q[0].wdata});
                    end
                end
            end
        end
    end

    task automatic push_if(input logic [31:0] a, input logic [31:0] rd);
        exp_t e;
        e = '{1'b0, 1'b0, a, 32'h0, 4'b0000, rd};
        q.push_back(e);
    endtask

    task automatic push_mem(input vec_t v);
        exp_t e;
        e = '{1'b1, v.mem_wr, v.mem_addr, v.mem_wdata, v.mem_wr ? v.mem_wstrb : 4'b0000, v.exp_mem_rdata};
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || dpend || bif.bus_req) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {63'h0, n < 300}, 64'h1);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        int   c0;
        int   b0;
        logic mem_first;
        aw_cfg   = v.aw;
        dw_cfg   = v.dw;
        same_cfg = v.same;
        @(posedge clk); #1;
        mem_first = !rr_mode || !model_last;
        if (v.do_mem && (mem_first || !v.do_if)) begin
            push_mem(v);
            if (v.do_if) push_if(v.if_addr, v.exp_if_rdata);
        end else begin
            if (v.do_if) push_if(v.if_addr, v.exp_if_rdata);
            if (v.do_mem) push_mem(v);
        end
        model_last    = q[$].is_mem;
        bif.if_req    = v.do_if;
        bif.if_addr   = v.if_addr;
        bif.mem_req   = v.do_mem;
        bif.mem_wr    = v.mem_wr;
        bif.mem_addr  = v.mem_addr;
        bif.mem_wdata = v.mem_wdata;
        bif.mem_wstrb = v.mem_wstrb;
        c0 = cyc;
        b0 = breq_cnt;
        @(posedge clk); #1;
        bif.if_req  = 1'b0;
        bif.mem_req = 1'b0;
        wait_idle();
        chk("latency", 64'(last_ready_cyc - c0), 64'(v.exp_lat));
        chk("bus_req_cycles", 64'(breq_cnt - b0), 64'(v.exp_breq));
    endtask

    initial begin
        int rc0;
`ifdef ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        //           if  if_addr        if_rdata       mem wr  mem_addr       wdata          wstrb    mem_rdata     aw dw same lat breq
        vecs[0] = '{1'b1, 32'hbfc00000, 32'h3c087fff, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 0, 1'b0, 3, 1};
        vecs[1] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h80000010, 32'h12345678, 4'b0011, 32'h0,        0, 0, 1'b0, 3, 1};
        vecs[2] = '{1'b1, 32'h00400004, 32'h1274567c, 1'b1, 1'b0, 32'h80000020, 32'h0,        4'b0000, 32'h92345658, 0, 0, 1'b0, 5, 2};
        vecs[3] = '{1'b1, 32'h00400008, 32'h12745670, 1'b1, 1'b1, 32'h80000030, 32'hdeadbeef, 4'b1111, 32'h0,        0, 0, 1'b0, 5, 2};
        vecs[4] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h80000100, 32'h0,        4'b0000, 32'h92345778, 3, 2, 1'b0, 8, 4};
        vecs[5] = '{1'b1, 32'h00400004, 32'h1274567c, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 0, 1'b1, 2, 1};
        vecs[6] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h80000040, 32'hffffffff, 4'b1111, 32'h92345638, 0, 0, 1'b0, 3, 1};

        reset         = 1'b1;
        bif.if_req    = 1'b0;
        bif.if_addr   = 32'h0;
        bif.mem_req   = 1'b0;
        bif.mem_wr    = 1'b0;
        bif.mem_addr  = 32'h0;
        bif.mem_wdata = 32'h0;
        bif.mem_wstrb = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_ctl", {58'h0, bif.bus_req, bif.bus_wr, bif.bus_wstrb}, 64'h0);
        chk("rst_bus_data", {bif.bus_addr, bif.bus_wdata}, 64'h0);
        chk("rst_if", {31'h0, bif.if_ready, bif.if_rdata}, 64'h0);
        chk("rst_mem", {31'h0, bif.mem_ready, bif.mem_rdata}, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // reset while the fetch sits in DATA; the late data_ok must be dropped
        aw_cfg = 0; dw_cfg = 1; same_cfg = 1'b0;
        @(posedge clk); #1;
        push_if(32'h00400010, 32'h0);
        model_last  = 1'b0;
        bif.if_req  = 1'b1;
        bif.if_addr = 32'h00400010;
        rc0 = ready_cnt;
        @(posedge clk); #1;
        bif.if_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_bus_req", {63'h0, bif.bus_req}, 64'h0);
        chk("mid_rst_ready", {62'h0, bif.if_ready, bif.mem_ready}, 64'h0);
        repeat (4) begin @(posedge clk); #1; end
        chk("no_ready_after_reset", 64'(ready_cnt - rc0), 64'h0);
        chk("stale_data_consumed", {63'h0, dpend}, 64'h0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
